// File: rtl/trigger_capture_controller.sv
// trigger_capture_controller
// Runs one oscilloscope acquisition around a trigger pulse. Samples stream
// into a circular buffer while a PRE_TRIG history builds up. The controller
// then waits for a trigger, or for a forced trigger in auto mode. It records
// DEPTH-PRE_TRIG more samples and then freezes the buffer until the display
// reports that it has read the frame.
//
// Ports
//   clk, reset       system clock, asynchronous active-high reset
//   sample_tick      one-cycle strobe: a new ADC sample is valid
//   trig_edge        one-cycle rising-edge trigger pulse
//   mode             00 auto, 01 normal, 10 single, 11 normal
//   arm              one-cycle pulse that starts a single-mode capture
//   display_done     one-cycle pulse: the display has read the held frame
//   wr_en, wr_addr   sample buffer write port (combinational)
//   frame_ready      a complete frame is held (registered)
//   frame_start      address of the oldest sample of the held frame (registered)
//   forced           the held frame came from the auto timeout (registered)
//   busy             capture in progress: PRE, ARMED or POST (registered)
module trigger_capture_controller #(
  parameter int ADDR_W     = 9,
  parameter int PRE_TRIG   = 128,
  parameter int AUTO_TICKS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              trig_edge,
  input  logic [1:0]        mode,
  input  logic              arm,
  input  logic              display_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_ready,
  output logic [ADDR_W-1:0] frame_start,
  output logic              forced,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_MAX = (DEPTH > AUTO_TICKS) ? DEPTH : AUTO_TICKS;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  PRE_C    = CNT_W'(PRE_TRIG);
  localparam logic [CNT_W-1:0]  POST_C   = CNT_W'(DEPTH - PRE_TRIG);
  localparam logic [CNT_W-1:0]  AUTO_C   = CNT_W'(AUTO_TICKS);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PRE_A    = ADDR_W'(PRE_TRIG);

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   trig_ptr_q, trig_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                forced_q, forced_d;
  logic                frame_ready_q, frame_ready_d;
  logic [ADDR_W-1:0]   frame_start_q, frame_start_d;
  logic                busy_q, busy_d;
  logic                capturing;
  logic                timeout;

  // Buffer write port: every sample is written while a capture is running.
  always_comb begin
    capturing = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    wr_en     = capturing && sample_tick;
    wr_addr   = ptr_q;
  end

  // Next-state, counter and frame bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    trig_ptr_d = trig_ptr_q;
    forced_d   = forced_q;
    cnt_inc    = cnt_q + CNT_ONE;
    ptr_d      = wr_en ? (ptr_q + ADDR_ONE) : ptr_q;
    // A real trigger arriving in the timeout cycle wins, so forced stays low.
    timeout    = (mode == MODE_AUTO) && (cnt_q == AUTO_C) && !trig_edge;

    case (state_q)
      S_IDLE: begin
        if ((mode != MODE_SINGLE) || arm) begin
          state_d  = S_PRE;
          cnt_d    = '0;
          forced_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        if (PRE_TRIG == 0) begin
          state_d = S_ARMED;
          cnt_d   = '0;
        end else if (sample_tick) begin
          if (cnt_inc == PRE_C) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_ARMED: begin
        if (trig_edge || timeout) begin
          // The sample written in the trigger cycle (if any) is POST sample 1.
          trig_ptr_d = ptr_q;
          forced_d   = timeout;
          cnt_d      = sample_tick ? CNT_ONE : '0;
          if (sample_tick && (POST_C == CNT_ONE)) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_POST;
          end
        end else if ((mode == MODE_AUTO) && sample_tick) begin
          cnt_d = cnt_inc;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_POST: begin
        if (sample_tick) begin
          if (cnt_inc == POST_C) begin
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_HOLD: begin
        if (display_done) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    frame_ready_d = (state_d == S_HOLD);
    frame_start_d = (state_d == S_HOLD) ? (trig_ptr_d - PRE_A) : '0;
    busy_d        = (state_d == S_PRE) || (state_d == S_ARMED) || (state_d == S_POST);
  end

  // State and output registers; reset discards any partial capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      trig_ptr_q    <= '0;
      cnt_q         <= '0;
      forced_q      <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_start_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      trig_ptr_q    <= trig_ptr_d;
      cnt_q         <= cnt_d;
      forced_q      <= forced_d;
      frame_ready_q <= frame_ready_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign frame_ready = frame_ready_q;
  assign frame_start = frame_start_q;
  assign forced      = forced_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_trigger_capture_controller.sv
module tb_trigger_capture_controller;

  localparam int ADDR_W     = 4;
  localparam int DEPTH      = 16;
  localparam int PRE_TRIG   = 4;
  localparam int AUTO_TICKS = 32;
  localparam int POST_LEN   = DEPTH - PRE_TRIG;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sample_tick = 1'b0;
  logic              trig_edge = 1'b0;
  logic [1:0]        mode = 2'b01;
  logic              arm = 1'b0;
  logic              display_done = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              frame_ready;
  logic [ADDR_W-1:0] frame_start;
  logic              forced;
  logic              busy;

  trigger_capture_controller #(
    .ADDR_W(ADDR_W), .PRE_TRIG(PRE_TRIG), .AUTO_TICKS(AUTO_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .trig_edge(trig_edge),
    .mode(mode), .arm(arm), .display_done(display_done), .wr_en(wr_en),
    .wr_addr(wr_addr), .frame_ready(frame_ready), .frame_start(frame_start),
    .forced(forced), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Inputs to apply at the next cycle.
  bit       nx_rst = 1'b1, nx_tick = 1'b0, nx_trig = 1'b0, nx_arm = 1'b0, nx_done = 1'b0;
  logic [1:0] nx_mode = 2'b01;

  // Reference model: acquisition progress expressed as sample counts.
  bit m_waiting;     // no acquisition running, none held
  bit m_holding;     // a complete frame is held
  bit m_triggered;   // trigger seen in the current acquisition
  bit m_forced;
  int m_ptr, m_history, m_after, m_auto_wait, m_start;

  int obs_writes = 0;
  int first_addr = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_waiting = 1'b1; m_holding = 1'b0; m_triggered = 1'b0; m_forced = 1'b0;
    m_ptr = 0; m_history = 0; m_after = 0; m_auto_wait = 0; m_start = 0;
  endtask

  task automatic compare_outputs();
    bit running;
    running = !m_waiting && !m_holding;
    check_eq("wr_en", wr_en, running && nx_tick);
    check_eq("wr_addr", wr_addr, m_ptr);
    check_eq("frame_ready", frame_ready, m_holding);
    check_eq("frame_start", frame_start, m_holding ? m_start : 0);
    check_eq("forced", forced, m_forced);
    check_eq("busy", busy, running);
  endtask

  task automatic model_update();
    bit wrote;
    wrote = 1'b0;
    if (m_holding) begin
      if (nx_done) begin m_holding = 1'b0; m_waiting = 1'b1; end
    end else if (m_waiting) begin
      if (nx_mode != 2'b10 || nx_arm) begin
        m_waiting = 1'b0; m_triggered = 1'b0; m_forced = 1'b0;
        m_history = 0; m_after = 0; m_auto_wait = 0;
      end
    end else begin
      wrote = nx_tick;
      if (m_history < PRE_TRIG) begin
        if (nx_tick) m_history++;
      end else if (!m_triggered) begin
        if (nx_trig || (nx_mode == 2'b00 && m_auto_wait == AUTO_TICKS)) begin
          m_triggered = 1'b1;
          m_forced = !nx_trig;
          m_start = (m_ptr - PRE_TRIG) & (DEPTH - 1);
          m_after = nx_tick ? 1 : 0;
        end else if (nx_mode == 2'b00 && nx_tick) begin
          m_auto_wait++;
        end
      end else if (nx_tick) begin
        m_after++;
      end
      if (m_triggered && m_after == POST_LEN) m_holding = 1'b1;
    end
    if (wrote) m_ptr = (m_ptr + 1) % DEPTH;
  endtask

  task automatic cycle();
    @(negedge clk);
    reset = nx_rst; sample_tick = nx_tick; trig_edge = nx_trig;
    mode = nx_mode; arm = nx_arm; display_done = nx_done;
    #1;
    if (nx_rst) model_reset();
    compare_outputs();
    if (!nx_rst) begin
      if (wr_en) begin
        obs_writes++;
        if (first_addr < 0) first_addr = int'(wr_addr);
      end
      model_update();
    end
    nx_trig = 1'b0; nx_arm = 1'b0; nx_done = 1'b0;
  endtask

  task automatic do_reset();
    nx_rst = 1'b1; nx_tick = 1'b0;
    cycle();
    cycle();
    nx_rst = 1'b0;
    obs_writes = 0;
    first_addr = -1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_auto(input bit trig_at_timeout);
    do_reset();
    nx_mode = 2'b00; nx_tick = 1'b1;
    for (int c = 0; c < 50; c++) begin
      // idle 0, PRE 1..4, ARMED ticks 5..36, timeout cycle 37
      if (trig_at_timeout && c == 37) nx_trig = 1'b1;
      cycle();
    end
    check_eq("auto_ready", frame_ready, 1);
    check_eq("auto_forced", forced, !trig_at_timeout);
    check_eq("auto_start", frame_start, 0);
    check_eq("auto_writes", obs_writes, 4 + 32 + 12);
  endtask

  initial begin
    model_reset();
    do_reset();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_addr", wr_addr, 0);

    // Normal mode, trigger 10 ticks in, a stray trigger in PRE and in HOLD.
    nx_mode = 2'b01; nx_tick = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c == 2 || c == 11) nx_trig = 1'b1;
      cycle();
    end
    check_eq("norm_ready", frame_ready, 1);
    check_eq("norm_start", frame_start, 6);
    check_eq("norm_forced", forced, 0);
    check_eq("norm_writes", obs_writes, 22);
    nx_trig = 1'b1; cycle();
    nx_trig = 1'b1; cycle();
    check_eq("hold_writes", obs_writes, 22);
    nx_done = 1'b1; cycle();
    run(3);
    check_eq("restart_busy", busy, 1);

    // Auto timeout, then a real trigger landing on the timeout cycle.
    run_auto(1'b0);
    run_auto(1'b1);

    // Single mode: nothing until arm, nothing again after the frame is read.
    do_reset();
    nx_mode = 2'b10; nx_tick = 1'b1;
    run(100);
    check_eq("single_idle", obs_writes, 0);
    nx_arm = 1'b1; cycle();
    run(10);
    nx_trig = 1'b1; cycle();
    run(12);
    check_eq("single_ready", frame_ready, 1);
    nx_done = 1'b1; cycle();
    run(20);
    check_eq("single_after", obs_writes, 22);
    check_eq("single_busy", busy, 0);

    // Sparse ticks with the trigger in a non-tick cycle.
    do_reset();
    nx_mode = 2'b01;
    begin
      int mark;
      mark = 0;
      for (int c = 0; c <= 60; c++) begin
        nx_tick = (c % 3 == 0);
        nx_trig = (c == 20);
        cycle();
        if (c == 20) begin mark = obs_writes; first_addr = -1; end
      end
      check_eq("sparse_post", obs_writes - mark, 12);
      check_eq("sparse_trig_ptr", first_addr, 6);
      check_eq("sparse_start", frame_start, 2);
    end

    // Reset in the middle of POST.
    do_reset();
    nx_mode = 2'b01; nx_tick = 1'b1;
    run(8);
    nx_trig = 1'b1; cycle();
    run(3);
    nx_rst = 1'b1; cycle();
    check_eq("midrst_wr_en", wr_en, 0);
    check_eq("midrst_busy", busy, 0);
    nx_rst = 1'b0; first_addr = -1;
    run(6);
    check_eq("midrst_first", first_addr, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      nx_tick = ($urandom % 4) != 0;
      nx_trig = ($urandom % 16) == 0;
      nx_arm  = ($urandom % 20) == 0;
      nx_done = ($urandom % 8) == 0;
      if (($urandom % 50) == 0) nx_mode = 2'($urandom % 4);
      nx_rst = ($urandom % 400) == 0;
      cycle();
    end
    nx_rst = 1'b0;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trigger_capture_controller.md
# trigger_capture_controller

Sequences one oscilloscope acquisition around the rising-edge trigger pulse. It takes the one-cycle trigger pulse from the synchronous edge detector, the ADC sample strobe, the operator mode and arm commands, and the display handshake. It drives the write port of the circular sample buffer, reports where the captured frame starts, and holds the frame until the display has read it. It sits between the trigger path and the sample RAM / display reader.

## Interface
- ADDR_W, 9, sample buffer address width; DEPTH = 2**ADDR_W samples
- PRE_TRIG, 128, samples kept before the trigger; legal range 0..DEPTH-1
- AUTO_TICKS, 4096, sample ticks to wait in auto mode before a forced trigger; must be ≥1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- sample_tick  in  1  one-cycle strobe: a new ADC sample is valid this cycle
- trig_edge  in  1  one-cycle rising-edge trigger pulse
- mode  in  2  00 auto, 01 normal, 10 single, 11 treated as normal
- arm  in  1  one-cycle pulse that starts a capture in single mode
- display_done  in  1  one-cycle pulse: the display finished reading the frame
- wr_en  out  1  buffer write enable
- wr_addr  out  ADDR_W  buffer write address
- frame_ready  out  1  a complete frame is held in the buffer
- frame_start  out  ADDR_W  address of the oldest sample of the held frame
- forced  out  1  the held frame was triggered by the auto timeout
- busy  out  1  high in PRE, ARMED and POST

## Operation
- ptr (ADDR_W bits) is the address of the next write and wraps modulo DEPTH. It increments on every wr_en.
- wr_en = sample_tick while the state is PRE, ARMED or POST. wr_addr = ptr. Both are combinational.
- cnt counts sample ticks. It is wide enough for max(DEPTH, AUTO_TICKS).
- IDLE: in single mode, wait for arm; in any other mode, go to PRE on the next cycle. On leaving IDLE: cnt := 0, forced := 0.
- PRE: count sample ticks. After PRE_TRIG ticks, go to ARMED and clear cnt. With PRE_TRIG = 0, go to ARMED on the first cycle. trig_edge is ignored in PRE.
- ARMED: keep writing around the buffer. On trig_edge: trig_ptr := ptr (the address of the first post-trigger sample), cnt := 0, go to POST.
- ARMED, auto mode only: count sample ticks. When the count reaches AUTO_TICKS with no trigger, take the same action as trig_edge and set forced := 1.
- POST: after DEPTH − PRE_TRIG sample ticks, counting the tick in the trigger cycle if one is present, go to HOLD.
- HOLD: no writes. frame_ready = 1. frame_start = ptr, which is equal to trig_ptr − PRE_TRIG modulo DEPTH. On display_done, go to IDLE.
- Mode is sampled only in IDLE and in ARMED. A mode change during POST or HOLD affects the next capture only.
- display_done outside HOLD is ignored. arm outside IDLE is ignored.

## Timing
- Reset values: state IDLE, ptr 0, cnt 0, wr_en 0, wr_addr 0, frame_ready 0, frame_start 0, forced 0, busy 0. Reset mid-capture aborts the capture immediately and the partial frame is discarded.
- trig_edge and sample_tick in the same ARMED cycle: the sample written that cycle is the trigger sample (its address equals trig_ptr) and counts as POST sample 1.
- trig_edge without sample_tick: trig_ptr is the address of the next sample written.
- trig_edge in the cycle that the auto count reaches AUTO_TICKS: treat it as a real trigger; forced stays 0.
- frame_ready, frame_start and forced are registered. frame_ready rises in the cycle after the last POST write. It falls in the cycle after display_done.
- In auto and normal modes the next capture starts 2 cycles after display_done: HOLD → IDLE → PRE.

## Test plan
All scenarios use ADDR_W=4 (DEPTH=16), PRE_TRIG=4, AUTO_TICKS=32, and sample_tick every cycle unless stated otherwise.

- Normal mode: trig_edge 10 ticks after reset is released -> exactly 4+6+12 writes; frame_ready rises one cycle after the write to address 5 (22nd write); frame_start=6; forced=0.
- Auto mode, no trigger -> 4 PRE ticks + 32 ARMED ticks, then 12 POST writes; forced=1; frame_start = (ptr at timeout − 4) mod 16.
- Single mode: no arm for 100 cycles -> wr_en stays 0. Pulse arm, trigger, display_done -> state returns to IDLE and no further writes occur until the next arm.
- trig_edge during PRE and during HOLD -> ignored: capture length unchanged, and no writes in HOLD.
- sample_tick every 3rd cycle, with trig_edge in a non-tick cycle -> trig_ptr equals the address of the next write; total POST writes = 12.
- reset asserted in the middle of POST -> all outputs return to 0 in the same cycle. After release in normal mode, the capture restarts at ptr=0.
